// File: rtl/tug_pkg.sv
// ============================================================================
// tug_pkg : shared types for the tug-of-war light bar controller
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tug_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    WIN_L = 2'd1,
    WIN_R = 2'd2
  } game_state_t;

  typedef enum logic {
    SIDE_L = 1'b0,
    SIDE_R = 1'b1
  } side_t;

endpackage

`default_nettype wire

// File: rtl/key_edge.sv
// ============================================================================
// key_edge : one-bit rising-edge detector, history register resets to 1
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;

  // History resets high so a key held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (reset) r_q <= 1'b1;
    else       r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;

endmodule

`default_nettype wire

// File: rtl/tug_light_bar.sv
// ============================================================================
// tug_light_bar : tug-of-war playfield, one-hot light bar, win detect and
//                 saturating per-side scores. Define TUG_EDGE_DETECT_EN to
//                 treat L/R as levels and edge-detect them internally.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tug_light_bar
  import tug_pkg::*;
#(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  L,
  input  logic                  R,
  input  logic                  restart,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic                  winner_l,
  output logic                  winner_r,
  output logic [SCORE_W-1:0]    score_l,
  output logic [SCORE_W-1:0]    score_r
);

  localparam int                 POS_W     = $clog2(NUM_LIGHTS);
  localparam logic [POS_W-1:0]   C_POS     = POS_W'((NUM_LIGHTS - 1) / 2);
  localparam logic [POS_W-1:0]   C_POS_MAX = POS_W'(NUM_LIGHTS - 1);
  localparam logic [SCORE_W-1:0] C_SC_MAX  = {SCORE_W{1'b1}};

  game_state_t        r_state;
  game_state_t        w_state_nxt;
  logic [POS_W-1:0]   r_pos;
  logic [POS_W-1:0]   w_pos_nxt;
  logic [SCORE_W-1:0] r_score_l;
  logic [SCORE_W-1:0] r_score_r;
  logic               w_pl;
  logic               w_pr;
  logic               w_mv_l;
  logic               w_mv_r;
  logic               w_win_l;
  logic               w_win_r;

`ifdef TUG_EDGE_DETECT_EN
  key_edge u_edge_l (
    .clk    (clk),
    .reset  (reset),
    .i_d    (L),
    .o_rise (w_pl)
  );

  key_edge u_edge_r (
    .clk    (clk),
    .reset  (reset),
    .i_d    (R),
    .o_rise (w_pr)
  );
`else
  assign w_pl = L;
  assign w_pr = R;
`endif

  // Simultaneous presses cancel each other out.
  assign w_mv_l = w_pl & ~w_pr;
  assign w_mv_r = w_pr & ~w_pl;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= PLAY;
      r_pos   <= C_POS;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_win_l     = 1'b0;
    w_win_r     = 1'b0;
    if (restart) begin
      w_state_nxt = PLAY;
      w_pos_nxt   = C_POS;
    end else begin
      case (r_state)
        PLAY: begin
          if (w_mv_l) begin
            if (r_pos == C_POS_MAX) begin
              w_state_nxt = WIN_L;
              w_win_l     = 1'b1;
            end else begin
              w_pos_nxt = r_pos + POS_W'(1);
            end
          end else if (w_mv_r) begin
            if (r_pos == '0) begin
              w_state_nxt = WIN_R;
              w_win_r     = 1'b1;
            end else begin
              w_pos_nxt = r_pos - POS_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The win still lands when a counter is already full; only the count holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_score_l <= '0;
      r_score_r <= '0;
    end else begin
      if (w_win_l && (r_score_l != C_SC_MAX)) r_score_l <= r_score_l + SCORE_W'(1);
      if (w_win_r && (r_score_r != C_SC_MAX)) r_score_r <= r_score_r + SCORE_W'(1);
    end
  end

  assign lights   = (r_state == PLAY) ? (NUM_LIGHTS'(1) << r_pos) : '0;
  assign winner_l = (r_state == WIN_L);
  assign winner_r = (r_state == WIN_R);
  assign score_l  = r_score_l;
  assign score_r  = r_score_r;

endmodule

`default_nettype wire

// File: tb/tb_tug_light_bar.sv
// ============================================================================
// tb_tug_light_bar : directed self-checking bench for tug_light_bar
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tug_light_bar;

  logic       clk = 1'b0;
  logic       reset;
  logic       L;
  logic       R;
  logic       restart;
  logic [8:0] lights_a;
  logic [8:0] lights_b;
  logic       wl_a, wr_a, wl_b, wr_b;
  logic [2:0] sl_a, sr_a;
  logic [1:0] sl_b, sr_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tug_light_bar #(.NUM_LIGHTS(9), .SCORE_W(3)) u_dut_a (
    .clk      (clk),
    .reset    (reset),
    .L        (L),
    .R        (R),
    .restart  (restart),
    .lights   (lights_a),
    .winner_l (wl_a),
    .winner_r (wr_a),
    .score_l  (sl_a),
    .score_r  (sr_a)
  );

  tug_light_bar #(.NUM_LIGHTS(9), .SCORE_W(2)) u_dut_b (
    .clk      (clk),
    .reset    (reset),
    .L        (L),
    .R        (R),
    .restart  (restart),
    .lights   (lights_b),
    .winner_l (wl_b),
    .winner_r (wr_b),
    .score_l  (sl_b),
    .score_r  (sr_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One-cycle press, then returns at the negedge after the edge that took it.
  task automatic press(input logic l, input logic r);
    @(negedge clk);
    L = l;
    R = r;
    @(negedge clk);
    L = 1'b0;
    R = 1'b0;
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    L       = 1'b0;
    R       = 1'b0;
    restart = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(5);
    check("rst_lights", lights_a, 9'b000010000);
    check("rst_wl", wl_a, 0);
    check("rst_wr", wr_a, 0);
    check("rst_sl", sl_a, 0);
    check("rst_sr", sr_a, 0);

    press(1, 0);
    check("step1", lights_a, 9'b000100000);
    repeat (3) press(1, 0);
    check("step4", lights_a, 9'b100000000);
    press(1, 0);
    check("winl_lights", lights_a, 9'b000000000);
    check("winl_flag", wl_a, 1);
    check("winl_score", sl_a, 1);
    press(0, 1);
    press(0, 1);
    check("winl_hold_lights", lights_a, 9'b000000000);
    check("winl_hold_wl", wl_a, 1);
    check("winl_hold_wr", wr_a, 0);
    check("winl_hold_sr", sr_a, 0);

    do_restart();
    check("rs_lights", lights_a, 9'b000010000);
    check("rs_wl", wl_a, 0);
    check("rs_sl_kept", sl_a, 1);

    press(1, 1);
    check("both_cancel", lights_a, 9'b000010000);

`ifdef TUG_EDGE_DETECT_EN
    @(negedge clk);
    L = 1'b1;
    idle(10);
    L = 1'b0;
    idle(1);
    check("hold_one_step", lights_a, 9'b000100000);
`else
    @(negedge clk);
    L = 1'b1;
    idle(3);
    L = 1'b0;
    check("hold_three_steps", lights_a, 9'b010000000);
`endif
    do_restart();

    repeat (5) press(0, 1);
    check("winr_lights", lights_a, 9'b000000000);
    check("winr_flag", wr_a, 1);
    check("winr_score", sr_a, 1);
    @(negedge clk);
    restart = 1'b1;
    L       = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    L       = 1'b0;
    check("rs_press_pos", lights_a, 9'b000010000);
    check("rs_press_wr", wr_a, 0);
    check("rs_press_sr_kept", sr_a, 1);

    // Four left wins: the 2-bit counter must stop at 3 while winning again.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    for (int w = 0; w < 4; w++) begin
      if (w != 0) do_restart();
      repeat (5) press(1, 0);
    end
    check("sat_b_score", sl_b, 3);
    check("sat_b_win", wl_b, 1);
    check("sat_a_score", sl_a, 4);
    do_restart();

    for (int w = 0; w < 2; w++) begin
      repeat (5) press(0, 1);
      do_restart();
    end
    repeat (3) press(1, 0);
    check("pre_rst_lights", lights_a, 9'b010000000);
    check("pre_rst_sr", sr_a, 2);
    @(negedge clk);
    reset = 1'b1;
    L     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`ifndef TUG_EDGE_DETECT_EN
    L = 1'b0;
`endif
    check("mid_rst_lights", lights_a, 9'b000010000);
    check("mid_rst_sl", sl_a, 0);
    check("mid_rst_sr", sr_a, 0);
    check("mid_rst_wl", wl_a, 0);
    idle(3);
    L = 1'b0;
    idle(1);
    check("held_thru_rst", lights_a, 9'b000010000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tug_light_bar.md
# tug_light_bar

Parametrised tug-of-war playfield controller. It replaces the per-light on/off cells with a single position register that drives an N-light one-hot bar. It detects wins at either end, keeps a saturating score per side and supports restarting a round without a reset. It sits between the debounced/synchronised key inputs and the LED drivers.

## Interface
- NUM_LIGHTS, 9: number of lights; must be odd and ≥3; center index C = (NUM_LIGHTS-1)/2
- SCORE_W, 3: width of each score counter
- clk  input  1  system clock
- reset  input  1  synchronous, active-high; returns the block to the start of a fresh game
- L  input  1  left key, synchronised level (or single-cycle pulse, see Configuration)
- R  input  1  right key, synchronised level (or single-cycle pulse)
- restart  input  1  single-cycle pulse; starts a new round and keeps the scores
- lights  output  NUM_LIGHTS  one-hot playfield; bit NUM_LIGHTS-1 is leftmost, bit 0 is rightmost
- winner_l  output  1  left player has won the current round
- winner_r  output  1  right player has won the current round
- score_l  output  SCORE_W  left rounds won, saturating
- score_r  output  SCORE_W  right rounds won, saturating

## Operation
- Press pulses: pl = left press, pr = right press. A press counts only when exactly one side is pressed: mv_l = pl & ~pr, mv_r = pr & ~pl. Simultaneous presses cancel.
- State machine, states PLAY, WIN_L, WIN_R:
  - PLAY, mv_l, pos < NUM_LIGHTS-1: pos <= pos+1.
  - PLAY, mv_l, pos == NUM_LIGHTS-1: go to WIN_L; score_l increments.
  - PLAY, mv_r, pos > 0: pos <= pos-1.
  - PLAY, mv_r, pos == 0: go to WIN_R; score_r increments.
  - WIN_L / WIN_R: L and R are ignored and the state holds.
  - Any state, restart: go to PLAY with pos <= C. Scores are unchanged.
- Priority: reset > restart > key moves. A restart in the same cycle as a press discards the press.
- Outputs:
  - lights = one-hot(pos) in PLAY; all zeros in WIN_L and WIN_R.
  - winner_l = (state==WIN_L); winner_r = (state==WIN_R).
- Score counters saturate at 2^SCORE_W-1. At saturation they do not wrap, and the win still happens.
- pos width is $clog2(NUM_LIGHTS). pos never leaves the range 0..NUM_LIGHTS-1.

## Timing
- Reset values:
  - state = PLAY, pos = C, so lights = one-hot(C).
  - winner_l = winner_r = 0.
  - score_l = score_r = 0.
  - Edge-detect history registers = 1.
- Latency: a press sampled at edge k changes lights, winners and scores at edge k, so the change is visible from cycle k+1. This is one cycle, and all outputs are registered or decoded from registers only.
- At most one position step per press. A key held at level causes exactly one step when the edge detector is enabled.
- Reset asserted mid-round or while in a WIN state: at the next edge all registers take their reset values, and the scores are cleared.

## Configuration
- TUG_EDGE_DETECT_EN defined:
  - L and R are levels. pl = L & ~L_q and pr = R & ~R_q, where L_q and R_q are the registered previous samples.
  - The history registers reset to 1, so a key held through reset does not register a press.
- TUG_EDGE_DETECT_EN undefined:
  - L and R are single-cycle pulses from upstream, and pl = L, pr = R.
  - No history registers are built. A held level steps once per cycle.

## Structure
- Shared package tug_pkg:
  - game_state_t enum {PLAY, WIN_L, WIN_R}, 2-bit
  - side_t enum {SIDE_L, SIDE_R}
- Sub-module key_edge: a one-bit rising-edge detector with synchronous reset to 1. Instantiate it twice, only under TUG_EDGE_DETECT_EN.
- Top level holds the FSM, the pos register, the one-hot decode and the two saturating counters.

## Test plan
- Reset, then idle 5 cycles -> lights=9'b000010000, winner_l=winner_r=0, both scores 0.
- Four separate L presses (edge mode) -> pos 8, lights=9'b100000000. A fifth L press -> next cycle lights=0, winner_l=1, score_l=1. Further R presses leave all outputs unchanged.
- L and R rising in the same cycle -> lights unchanged. Holding L high for 10 cycles -> exactly one step left.
- In WIN_R, restart pulse -> next cycle lights=one-hot(4), winner_r=0, score_r kept. Restart coincident with an L press -> pos=4, not 5.
- SCORE_W=2: four left wins -> score_l saturates at 3 and the fourth win still sets winner_l.
- Reset asserted at pos=7 with score_r=2 -> next cycle pos=4, scores 0. Key held high through reset release -> no step (edge mode).
